// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer:
// register offsets within the 4-word window, CTRL/STATUS bit positions,
// and the countdown state encoding.
package timer_pkg;

  // Register offsets, selected by addr[1:0]
  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] LOAD_OFF   = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;
  localparam logic [1:0] STATUS_OFF = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_AUTO_BIT  = 1;
  localparam int unsigned CTRL_IRQ_BIT   = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  // STATUS bit positions
  localparam int unsigned STAT_EXP_BIT = 0;
  localparam int unsigned STAT_RUN_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mmio_timer_if.sv
// Shared CPU memory-port view of the timer.
// master: CPU side drives addr/we/wd, observes rd/sel/irq.
// slave : timer side consumes addr/we/wd, drives rd/sel/irq.
interface mmio_timer_if #(
  parameter int unsigned DW = 32
);
  logic [31:0]   addr;
  logic          we;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;
  logic          sel;
  logic          irq;

  modport master (output addr, output we, output wd,
                  input  rd,   input  sel, input irq);
  modport slave  (input  addr, input  we,  input wd,
                  output rd,   output sel, output irq);
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for the countdown timer: counts cycles while enabled and
// pulses tick when the count reaches prescale, then restarts from 0.
// Ports: CLK, RSTn (async active-low), clear (restart count),
//        enable (count while high), prescale (terminal value), tick (comb).
module timer_prescaler #(
  parameter int unsigned PW = 8
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] prescale,
  output logic          tick
);

  logic [PW-1:0] presc_cnt_q, presc_cnt_d;

  assign tick = enable && (presc_cnt_q == prescale);

  // Next count: clear dominates, otherwise wrap on tick
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (clear) begin
      presc_cnt_d = '0;
    end else if (enable) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) presc_cnt_q <= '0;
    else       presc_cnt_q <= presc_cnt_d;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with prescaler, optional auto-reload,
// sticky expiry flag and level interrupt.
// Ports: CLK, RSTn (async active-low), bus (slave modport: addr/we/wd in,
//        rd/sel combinational out, irq = expired & irq_en from flops).
module mmio_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned DW        = 32,
  parameter int unsigned PW        = 8
) (
  input  logic         CLK,
  input  logic         RSTn,
  mmio_timer_if.slave  bus
);

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic          auto_q, auto_d;
  logic          irq_en_q, irq_en_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [DW-1:0] load_q, load_d;
  logic [DW-1:0] count_q, count_d;
  logic          expired_q, expired_d;

  logic          sel_c;
  logic [1:0]    off_c;
  logic          wr_ctrl_c, wr_load_c, wr_count_c, wr_status_c;
  logic          tick_c, tick_eff_c, expire_c, presc_clear_c;
  logic [DW-1:0] rd_c;

  // Address decode and write strobes
  assign sel_c       = (bus.addr[31:2] == BASE_ADDR[31:2]);
  assign off_c       = bus.addr[1:0];
  assign wr_ctrl_c   = bus.we && sel_c && (off_c == CTRL_OFF);
  assign wr_load_c   = bus.we && sel_c && (off_c == LOAD_OFF);
  assign wr_count_c  = bus.we && sel_c && (off_c == COUNT_OFF);
  assign wr_status_c = bus.we && sel_c && (off_c == STATUS_OFF);

  // A COUNT write on a tick edge swallows the tick
  assign tick_eff_c    = tick_c && !wr_count_c;
  assign expire_c      = tick_eff_c && (count_q <= DW'(1));
  assign presc_clear_c = wr_count_c ||
                         ((state_q == IDLE) && wr_ctrl_c && bus.wd[CTRL_EN_BIT]);

  timer_prescaler #(.PW(PW)) u_prescaler (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .clear    (presc_clear_c),
    .enable   (state_q == RUN),
    .prescale (prescale_q),
    .tick     (tick_c)
  );

  // Register updates and countdown FSM
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    count_d    = count_q;
    expired_d  = expired_q;

    if (wr_ctrl_c) begin
      en_d       = bus.wd[CTRL_EN_BIT];
      auto_d     = bus.wd[CTRL_AUTO_BIT];
      irq_en_d   = bus.wd[CTRL_IRQ_BIT];
      prescale_d = bus.wd[CTRL_PRESC_LSB +: PW];
    end

    if (wr_load_c) load_d = bus.wd;

    if (wr_count_c) begin
      count_d = bus.wd;
    end else if (tick_eff_c) begin
      if (count_q > DW'(1)) count_d = count_q - DW'(1);
      else                  count_d = auto_q ? load_q : '0;
    end

    // Set beats write-1-to-clear
    if (expire_c)                               expired_d = 1'b1;
    else if (wr_status_c && bus.wd[STAT_EXP_BIT]) expired_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_ctrl_c && bus.wd[CTRL_EN_BIT]) state_d = RUN;
      end
      RUN: begin
        // An explicit CTRL write decides en over a one-shot expiry
        if (wr_ctrl_c) begin
          state_d = bus.wd[CTRL_EN_BIT] ? RUN : IDLE;
        end else if (expire_c && !auto_q) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      load_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
    end
  end

  // Combinational read mux, zero when not selected
  always_comb begin
    rd_c = '0;
    if (sel_c) begin
      unique case (off_c)
        CTRL_OFF: begin
          rd_c[CTRL_EN_BIT]            = en_q;
          rd_c[CTRL_AUTO_BIT]          = auto_q;
          rd_c[CTRL_IRQ_BIT]           = irq_en_q;
          rd_c[CTRL_PRESC_LSB +: PW]   = prescale_q;
        end
        LOAD_OFF:  rd_c = load_q;
        COUNT_OFF: rd_c = count_q;
        STATUS_OFF: begin
          rd_c[STAT_EXP_BIT] = expired_q;
          rd_c[STAT_RUN_BIT] = (state_q == RUN);
        end
        default: rd_c = '0;
      endcase
    end
  end

  assign bus.rd  = rd_c;
  assign bus.sel = sel_c;
  assign bus.irq = expired_q && irq_en_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized
// one-shot/auto-reload runs checked against expiry-time arithmetic.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mmio_timer_if #(.DW(32)) bus ();

  mmio_timer dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end in the low phase of the clock
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    bus.addr = BASE + 32'(off);
    bus.wd   = d;
    bus.we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.we   = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] off, output logic [31:0] v);
    bus.addr = BASE + 32'(off);
    bus.we   = 1'b0;
    #1;
    v = bus.rd;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] v;
    rd_reg(off, v);
    check(tag, v, exp);
  endtask

  initial begin
    logic [31:0] v;
    int n, p, t, k, exp_cnt;
    bit auto_m, irq_m;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.addr = '0;
    bus.we   = 1'b0;
    bus.wd   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 4; i++) chk_reg($sformatf("reset_off%0d", i), 2'(i), 32'h0);
    check("reset_irq", 32'(bus.irq), 32'h0);
    check("sel_in_window", 32'(bus.sel), 32'h1);
    bus.addr = 32'h0000_0104;
    #1;
    check("sel_out_window", 32'(bus.sel), 32'h0);
    check("rd_out_window", bus.rd, 32'h0);

    // One-shot, prescale 0: expiry 5 cycles after enable
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd5);
    wr(2'd0, 32'h0000_0005);
    cyc(4);
    chk_reg("oneshot_pre_exp", 2'd3, 32'h1 << 1);
    check("oneshot_pre_irq", 32'(bus.irq), 32'h0);
    cyc(1);
    chk_reg("oneshot_status", 2'd3, 32'h1);
    check("oneshot_irq", 32'(bus.irq), 32'h1);
    chk_reg("oneshot_count", 2'd2, 32'h0);
    chk_reg("oneshot_ctrl", 2'd0, 32'h0000_0004);
    wr(2'd3, 32'hFFFF_FFFF);
    chk_reg("oneshot_w1c", 2'd3, 32'h0);

    // Auto-reload, prescale 2: expiry every 9 cycles
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h0000_0203);
    cyc(8);
    chk_reg("auto_pre_exp", 2'd3, 32'h2);
    cyc(1);
    chk_reg("auto_exp", 2'd3, 32'h3);
    chk_reg("auto_reload_count", 2'd2, 32'd3);
    check("auto_irq_gated", 32'(bus.irq), 32'h0);
    wr(2'd3, 32'h1);                 // edge 10
    chk_reg("auto_w1c", 2'd3, 32'h2);
    cyc(7);                          // edge 17
    chk_reg("auto_pre_exp2", 2'd3, 32'h2);
    cyc(1);                          // edge 18
    chk_reg("auto_exp2", 2'd3, 32'h3);
    cyc(8);                          // edge 26
    wr(2'd3, 32'h1);                 // W1C on expiry edge 27
    chk_reg("w1c_vs_set", 2'd3, 32'h3);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h1);

    // COUNT write on a tick edge wins and restarts the prescaler
    wr(2'd2, 32'd20);
    wr(2'd0, 32'h0000_0101);         // prescale 1: ticks at edges 2,4,...
    cyc(1);
    wr(2'd2, 32'd10);                // edge 2
    chk_reg("cnt_wr_wins", 2'd2, 32'd10);
    cyc(1);
    chk_reg("cnt_presc_cleared", 2'd2, 32'd10);
    cyc(1);
    chk_reg("cnt_after_tick", 2'd2, 32'd9);
    wr(2'd0, 32'h0);

    // Disable mid-run holds COUNT, re-enable resumes
    wr(2'd2, 32'd20);
    wr(2'd0, 32'h0000_0001);
    cyc(6);
    wr(2'd0, 32'h0);                 // edge 7
    chk_reg("dis_count", 2'd2, 32'd13);
    cyc(50);
    chk_reg("dis_hold_count", 2'd2, 32'd13);
    chk_reg("dis_no_exp", 2'd3, 32'h0);
    wr(2'd0, 32'h0000_0005);
    cyc(12);
    chk_reg("reen_pre_exp", 2'd3, 32'h2);
    cyc(1);
    chk_reg("reen_exp", 2'd3, 32'h1);
    check("reen_irq", 32'(bus.irq), 32'h1);
    wr(2'd3, 32'h1);

    // Randomized runs against expiry arithmetic
    for (int it = 0; it < 12; it++) begin
      n      = int'($urandom_range(0, 12));
      p      = int'($urandom_range(0, 3));
      auto_m = 1'($urandom_range(0, 1));
      irq_m  = 1'($urandom_range(0, 1));
      t      = ((n < 1) ? 1 : n) * (p + 1);
      wr(2'd1, 32'(n));
      wr(2'd2, 32'(n));
      wr(2'd0, 32'(p << 8) | 32'(irq_m) << 2 | 32'(auto_m) << 1 | 32'h1);
      k = int'($urandom_range(0, t - 1));
      cyc(k);
      exp_cnt = n - k / (p + 1);
      chk_reg($sformatf("rnd%0d_mid_count", it), 2'd2, 32'(exp_cnt));
      cyc(t - 1 - k);
      chk_reg($sformatf("rnd%0d_pre_exp", it), 2'd3, 32'h2);
      cyc(1);
      chk_reg($sformatf("rnd%0d_status", it), 2'd3, {30'h0, auto_m, 1'b1});
      check($sformatf("rnd%0d_irq", it), 32'(bus.irq), 32'(irq_m));
      chk_reg($sformatf("rnd%0d_count", it), 2'd2, auto_m ? 32'(n) : 32'h0);
      wr(2'd0, 32'h0);
      wr(2'd3, 32'h1);
    end

    // Async reset mid-count
    wr(2'd1, 32'd7);
    wr(2'd2, 32'd10);
    wr(2'd0, 32'h0000_0005);
    cyc(6);
    chk_reg("pre_rst_count", 2'd2, 32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk_reg($sformatf("arst_off%0d", i), 2'(i), 32'h0);
    check("arst_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(30);
    chk_reg("post_rst_status", 2'd3, 32'h0);
    chk_reg("post_rst_count", 2'd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped down-counting timer peripheral on the CPU's shared word-addressed memory port (addr, we, wd, rd), in parallel with the instruction/data memory.
- Asserts sel when addr falls in its window, so the top-level read mux selects its rd instead of memory rd.
- Provides a one-shot or auto-reload countdown with prescaler, a sticky expiry flag and a level interrupt.
- Gives programs running on the multi-cycle core a time base and polling/IRQ target.

Parameters:
- BASE_ADDR, 32'h0000_0100: word address of register 0; window is BASE_ADDR..BASE_ADDR+3.
- DW, 32: data and counter width.
- PW, 8: prescaler width.

Ports:
- CLK, input, 1: system clock, rising edge.
- RSTn, input, 1: asynchronous active-low reset.
- addr, input, 32: word address from the CPU address mux.
- we, input, 1: write strobe, sampled on the rising edge of CLK.
- wd, input, DW: write data.
- rd, output, DW: combinational read data; 0 when sel=0.
- sel, output, 1: combinational; 1 when addr[31:2]==BASE_ADDR[31:2].
- irq, output, 1: level interrupt = status.expired & ctrl.irq_en, driven from flops only.

Behaviour:
- Register map, offset = addr[1:0]:
  - 0 CTRL (RW): [0] en, [1] auto_reload, [2] irq_en, [8+PW-1:8] prescale; other bits read 0.
  - 1 LOAD (RW): reload value.
  - 2 COUNT (RW): current count; a write loads it directly.
  - 3 STATUS: [0] expired (sticky, write-1-to-clear); [1] running (RO, = state==RUN).
- Writes take effect when we & sel are high at the CLK edge. Reads are combinational, same cycle, with no read side effects.
- Reset (async, immediate): CTRL=0, LOAD=0, COUNT=0, expired=0, prescaler count=0, state=IDLE. Outputs: rd=0 when unselected, irq=0.
- State machine:
  - IDLE: en=0 and counter frozen. A write to CTRL with en=1 -> RUN, prescaler cleared.
  - RUN: prescaler increments each cycle; tick when prescaler==prescale, then prescaler returns to 0. A tick therefore occurs every prescale+1 cycles; prescale=0 gives a tick every cycle.
  - On tick with COUNT>1: COUNT <= COUNT-1.
  - On tick with COUNT<=1: expired <= 1.
    - auto_reload=1: COUNT <= LOAD, stay in RUN.
    - auto_reload=0: COUNT <= 0, en <= 0, go to IDLE.
  - Writing en=0 in RUN -> IDLE at that edge; COUNT holds its value.
- Latency: with COUNT=N≥1 and prescale=P at the enabling write, expired rises N*(P+1) cycles after that write edge. irq follows expired in the same cycle.
- Simultaneous events:
  - CPU write to COUNT on the same edge as a tick: the write wins, the tick is discarded and the prescaler is cleared.
  - W1C of expired on the same edge as a new expiry: the set wins, expired stays 1.
  - CPU write to CTRL clearing en on the same edge as a tick-expiry: the write wins for en; expired is still set.
  - Write to LOAD during a reload tick: the reload uses the old LOAD; the new value is used from the next reload.
- Arithmetic: COUNT decrement is modulo 2^DW but never underflows; the COUNT<=1 rule catches 0 and 1. Writes to offset 3 ignore all bits except [0].
- Reset asserted mid-count: all state returns to reset values immediately. No tick or expiry is produced after RSTn deasserts until re-enabled.

Decomposition:
- Shared package timer_pkg holds:
  - Register offset constants: CTRL_OFF=2'd0, LOAD_OFF=2'd1, COUNT_OFF=2'd2, STATUS_OFF=2'd3.
  - CTRL bit-position constants.
  - State enum: IDLE, RUN.
- One sub-module: timer_prescaler. Inputs: CLK, RSTn, clear, enable, prescale. Output: tick. Holds the prescaler counter.
- Register file, decode and countdown FSM stay in mmio_timer.

Test Plan:
- Reset, then read offsets 0-3 at BASE_ADDR -> all rd=0, irq=0. Read addr 0x104 -> sel=0, rd=0.
- One-shot: write LOAD=5, COUNT=5, CTRL=32'h0000_0005 (en, irq_en, prescale=0) -> expired and irq rise exactly 5 cycles after the CTRL write edge. Then COUNT=0, running=0, CTRL[0]=0.
- Auto-reload with prescale: LOAD=3, COUNT=3, CTRL=32'h0000_0203 (prescale=2, auto) -> expiry at cycle 9, COUNT reloads to 3, running stays 1. Write STATUS=1 -> expired=0. Next expiry 9 cycles after the reload.
- Collision: with a tick due, write COUNT=10 on that edge -> COUNT reads 10, no decrement. Arrange a W1C of STATUS on an expiry edge -> expired reads 1.
- Disable mid-run: COUNT=20 running, write CTRL=0 after 7 cycles -> COUNT holds 13, no expiry for 50 cycles. Re-enable -> resumes from 13.
- Async reset mid-count: assert RSTn=0 between clock edges while COUNT=4 -> all registers 0 immediately. After release, no expiry without a new enable.
